disp_ctrl: RTL and testbench
============================

DISP_CTRL -- requirements
Module: disp_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per sclk half-period (legal 1..255).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 dis  input  1  frame strobe from game controller, one-cycle pulse, qualifies disdata.
REQ-005 disdata  input  23  frame image: barrier columns plus car row, bit 0 shifted out last.
REQ-006 busy  output  1  high while a frame is being shifted or latched.
REQ-007 sclk  output  1  shift clock to external 74HC595-style chain (3 devices, 24 bits).
REQ-008 sdo  output  1  serial data to chain, sampled by chain on sclk rising edge.
REQ-009 rclk  output  1  storage-register latch pulse to chain.
REQ-010 overrun  output  1  one-cycle pulse when a pending frame is overwritten.
REQ-011 oe_n  output  1  chain output enable, active-low (see Configuration).

Function
REQ-012 States SHALL be IDLE, SHIFT, LATCH; no other reachable states.
REQ-013 IDLE with dis=1 SHALL capture disdata into shadow register and enter SHIFT next cycle.
REQ-014 Shifted word SHALL be 24 bits: pad 0 first, then disdata[22] down to disdata[0].
REQ-015 On SHIFT entry: bit index 0, sclk=0, sdo=pad bit.
REQ-016 sclk SHALL toggle every CLK_DIV cycles; sdo SHALL change only on the cycle sclk falls (and on SHIFT entry).
REQ-017 After the 24th rising edge and its high phase (48 half-periods), SHALL enter LATCH with sclk=0.
REQ-018 LATCH: rclk=1 for exactly CLK_DIV cycles, then rclk=0 and IDLE (or SHIFT per REQ-021).
REQ-019 busy SHALL be high from the cycle after capture through the last LATCH cycle: 49*CLK_DIV cycles per frame (196 at default).
REQ-020 dis while busy SHALL store disdata in a one-deep pending register and set pending flag.
REQ-021 At LATCH exit with pending set, SHALL load pending into shadow, clear flag, enter SHIFT directly (busy stays high).
REQ-022 dis while busy and pending already set SHALL overwrite pending (newest wins) and pulse overrun for one cycle.
REQ-023 dis on the same cycle as LATCH exit SHALL be treated as pending (REQ-021 uses the new data); no overrun.
REQ-024 Half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide minimum; bit index 5 bits, wraps never (bounded 0..23).
REQ-025 dis in IDLE and shadow contents SHALL have no effect on outputs until SHIFT entry.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, busy=0, sclk=0, sdo=0, rclk=0, overrun=0, pending flag=0, shadow=0, counters=0.
REQ-027 oe_n reset value SHALL be 1 with DISP_BLANK_EN, 0 without.
REQ-028 Reset mid-frame SHALL abort the frame with no rclk pulse; chain storage keeps last latched image.
REQ-029 Release of rst_n SHALL be sampled synchronously; first dis accepted on the first clk edge with rst_n high.

Configuration
REQ-030 Macro DISP_BLANK_EN: when defined, oe_n SHALL be 1 from reset until the end of the first LATCH, then 0 permanently (blank display until first valid frame).
REQ-031 When DISP_BLANK_EN undefined, oe_n SHALL be constant 0; all other behaviour identical.

Verification
REQ-032 Reset release, dis with disdata=23'h7FFFFF, CLK_DIV=4 -> sdo bits 0,1x23 on sclk rises, 24 rises, rclk high 4 cycles, busy high 196 cycles.
REQ-033 disdata=23'h000004 (car centre, no barriers) -> last captured serial bits ...0,0,1,0,0, chain image equals 24'h000004.
REQ-034 Second dis 10 cycles into frame A with data B -> no overrun, B shifted immediately after A's LATCH, busy never drops.
REQ-035 Three dis (A, B, C) within one frame -> one overrun pulse at C, frames A then C output, B never shifted.
REQ-036 rst_n low at bit 12 -> outputs at reset values same cycle, no rclk; next dis produces complete correct frame.
REQ-037 DISP_BLANK_EN defined -> oe_n=1 after reset, falls the cycle after first rclk falls; undefined -> oe_n=0 throughout.

Source files
------------

// File: rtl/disp_ctrl.sv
// Serial display driver: shifts a 23-bit frame (plus a leading pad bit) into a 24-bit 595-style chain.
// Optional macro DISP_BLANK_EN keeps oe_n high until the first frame has been latched.
module disp_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dis,
  input  logic [22:0] disdata,
  output logic        busy,
  output logic        sclk,
  output logic        sdo,
  output logic        rclk,
  output logic        overrun,
  output logic        oe_n
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_BIT = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
  logic [4:0]       bit_idx_reg, bit_idx_next;
  logic [22:0]      shadow_reg, shadow_next;
  logic [22:0]      pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             busy_reg, busy_next;
  logic             sclk_reg, sclk_next;
  logic             sdo_reg, sdo_next;
  logic             rclk_reg, rclk_next;
  logic             overrun_reg, overrun_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shadow_reg     <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      sclk_reg       <= 1'b0;
      sdo_reg        <= 1'b0;
      rclk_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shadow_reg     <= shadow_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      busy_reg       <= busy_next;
      sclk_reg       <= sclk_next;
      sdo_reg        <= sdo_next;
      rclk_reg       <= rclk_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    div_cnt_next    = div_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shadow_next     = shadow_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    busy_next       = busy_reg;
    sclk_next       = sclk_reg;
    sdo_next        = sdo_reg;
    rclk_next       = rclk_reg;
    overrun_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dis) begin
          shadow_next  = disdata;
          state_next   = SHIFT;
          busy_next    = 1'b1;
          div_cnt_next = '0;
          bit_idx_next = '0;
          sclk_next    = 1'b0;
          sdo_next     = 1'b0;
        end
      end

      SHIFT: begin
        if (dis) begin
          pend_next       = disdata;
          pend_valid_next = 1'b1;
          overrun_next    = pend_valid_reg;
        end
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else if (bit_idx_reg == LAST_BIT) begin
            sclk_next  = 1'b0;
            rclk_next  = 1'b1;
            state_next = LATCH;
          end else begin
            // Falling edge: present the next bit (pad is bit 0, disdata[22] is bit 1).
            sclk_next    = 1'b0;
            bit_idx_next = bit_idx_reg + 5'd1;
            sdo_next     = shadow_reg[5'd22 - bit_idx_reg];
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end

      LATCH: begin
        if (div_cnt_reg == DIV_LAST) begin
          rclk_next    = 1'b0;
          div_cnt_next = '0;
          if (dis || pend_valid_reg) begin
            // A strobe arriving on the exit cycle is newer than any stored frame.
            shadow_next     = dis ? disdata : pend_reg;
            overrun_next    = dis & pend_valid_reg;
            pend_valid_next = 1'b0;
            state_next      = SHIFT;
            bit_idx_next    = '0;
            sclk_next       = 1'b0;
            sdo_next        = 1'b0;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
          if (dis) begin
            pend_next       = disdata;
            pend_valid_next = 1'b1;
            overrun_next    = pend_valid_reg;
          end
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        sclk_next  = 1'b0;
        rclk_next  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_reg;
  assign sclk    = sclk_reg;
  assign sdo     = sdo_reg;
  assign rclk    = rclk_reg;
  assign overrun = overrun_reg;

`ifdef DISP_BLANK_EN
  logic rclk_d_reg;
  logic oe_n_reg;

  // Display is unblanked the cycle after the first latch pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rclk_d_reg <= 1'b0;
      oe_n_reg   <= 1'b1;
    end else begin
      rclk_d_reg <= rclk_reg;
      if (rclk_d_reg && !rclk_reg)
        oe_n_reg <= 1'b0;
    end
  end

  assign oe_n = oe_n_reg;
`else
  assign oe_n = 1'b0;
`endif

endmodule

// File: tb/tb_disp_ctrl.sv
// Randomized and directed bench for disp_ctrl, checked against a frame-level timing model
// and a behavioural model of the external 24-bit shift/storage chain.
module tb_disp_ctrl;
  localparam int D     = 4;
  localparam int FRAME = 49 * D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dis;
  logic [22:0] disdata;
  logic        busy, sclk, sdo, rclk, overrun, oe_n;

  disp_ctrl #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dis     (dis),
    .disdata (disdata),
    .busy    (busy),
    .sclk    (sclk),
    .sdo     (sdo),
    .rclk    (rclk),
    .overrun (overrun),
    .oe_n    (oe_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: remaining busy cycles, one-deep pending slot, expected images.
  int          rem = 0;
  bit          pend_v = 0;
  logic [22:0] pend_d = '0;
  logic [22:0] cur_d = '0;
  logic [22:0] exp_q[$];
  bit          ov_exp = 0;
  bit          oe_exp = 1;
  bit          fall_flag = 0;

  // External chain model.
  logic [23:0] shreg = '0;
  logic [23:0] image = '0;
  int          rises = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_rclk = 1'b0;
  int          busy_cnt = 0, rclk_cnt = 0, ov_cnt = 0;

  task automatic start_frame(input logic [22:0] d);
    exp_q.push_back(d);
    cur_d = d;
    rem   = FRAME;
  endtask

  task automatic model_reset();
    rem       = 0;
    pend_v    = 0;
    exp_q.delete();
    ov_exp    = 0;
    oe_exp    = 1;
    fall_flag = 0;
    rises     = 0;
    prev_sclk = 1'b0;
    prev_rclk = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sclk"}, 32'(sclk), 32'd0);
    check({tag, "_sdo"}, 32'(sdo), 32'd0);
    check({tag, "_rclk"}, 32'(rclk), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
`ifdef DISP_BLANK_EN
    check({tag, "_oe_n"}, 32'(oe_n), 32'd1);
`else
    check({tag, "_oe_n"}, 32'(oe_n), 32'd0);
`endif
  endtask

  task automatic cycle(input bit dv, input logic [22:0] dd);
    bit          last;
    int          k, i;
    logic [23:0] w;
    dis     = dv;
    disdata = dd;
    @(posedge clk);
    last = (rem == 1);
    if (fall_flag) oe_exp = 0;
    fall_flag = last;
    ov_exp = 0;
    if (dv) begin
      if (rem <= 1) begin
        if (last) ov_exp = pend_v;
        pend_v = 0;
        start_frame(dd);
      end else begin
        ov_exp = pend_v;
        pend_v = 1;
        pend_d = dd;
        rem--;
      end
    end else if (last && pend_v) begin
      pend_v = 0;
      start_frame(pend_d);
    end else if (rem > 0) begin
      rem--;
    end
    #1;
    dis = 1'b0;
    check("busy", 32'(busy), 32'(rem > 0));
    check("rclk", 32'(rclk), 32'(rem > 0 && rem <= D));
    check("overrun", 32'(overrun), 32'(ov_exp));
`ifdef DISP_BLANK_EN
    check("oe_n", 32'(oe_n), 32'(oe_exp));
`else
    check("oe_n", 32'(oe_n), 32'd0);
`endif
    if (rem > D) begin
      k = FRAME - rem;
      i = k / (2 * D);
      w = {1'b0, cur_d};
      check("sclk", 32'(sclk), 32'((k / D) % 2));
      check("sdo", 32'(sdo), 32'(w[23-i]));
    end else begin
      check("sclk_low", 32'(sclk), 32'd0);
    end
    if (sclk && !prev_sclk) begin
      shreg = {shreg[22:0], sdo};
      rises++;
    end
    if (rclk && !prev_rclk) begin
      image = shreg;
      if (exp_q.size() == 0) begin
        check("unexpected_latch", 32'd1, 32'd0);
      end else begin
        check("image", 32'(image), 32'({1'b0, exp_q.pop_front()}));
        check("rises", 32'(rises), 32'd24);
      end
      rises = 0;
    end
    prev_sclk = sclk;
    prev_rclk = rclk;
    busy_cnt += int'(busy);
    rclk_cnt += int'(rclk);
    ov_cnt   += int'(overrun);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 23'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int b0, r0, o0;

  initial begin
    rst_n   = 1'b0;
    dis     = 1'b0;
    disdata = '0;
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones frame: 24 rises, 4-cycle latch, 196 busy cycles.
    b0 = busy_cnt; r0 = rclk_cnt;
    cycle(1'b1, 23'h7FFFFF);
    idle(FRAME + 10);
    check("ones_busy_len", 32'(busy_cnt - b0), 32'(FRAME));
    check("ones_rclk_len", 32'(rclk_cnt - r0), 32'(D));
    check("ones_image", 32'(image), 32'h7FFFFF);
    $display("frame ones: image=%06h busy=%0d rclk=%0d", image, busy_cnt - b0, rclk_cnt - r0);

    // Car in centre lane only.
    cycle(1'b1, 23'h000004);
    idle(FRAME + 10);
    check("car_image", 32'(image), 32'h000004);
    $display("frame car: image=%06h", image);

    // Second frame queued 10 cycles in: no overrun, back-to-back frames.
    o0 = ov_cnt; b0 = busy_cnt;
    cycle(1'b1, 23'h155555);
    idle(9);
    cycle(1'b1, 23'h2AAAAA);
    idle(2 * FRAME + 10);
    check("queue_overrun", 32'(ov_cnt - o0), 32'd0);
    check("queue_busy_len", 32'(busy_cnt - b0), 32'(2 * FRAME));
    check("queue_image", 32'(image), 32'h2AAAAA);
    $display("frames queued: image=%06h busy=%0d", image, busy_cnt - b0);

    // Three strobes in one frame: B dropped, one overrun pulse.
    o0 = ov_cnt;
    cycle(1'b1, 23'h0F0F0F);
    idle(5);
    cycle(1'b1, 23'h123456);
    idle(5);
    cycle(1'b1, 23'h654321);
    idle(2 * FRAME + 10);
    check("overrun_count", 32'(ov_cnt - o0), 32'd1);
    check("overrun_image", 32'(image), 32'h654321);
    $display("frames overrun: image=%06h overruns=%0d", image, ov_cnt - o0);

    // Reset at bit 12 aborts the frame; next frame is complete.
    r0 = rclk_cnt;
    cycle(1'b1, 23'h7ABCDE);
    idle(12 * 2 * D + 1);
    do_reset("midreset");
    check("midreset_no_rclk", 32'(rclk_cnt - r0), 32'd0);
    check("midreset_image_kept", 32'(image), 32'h654321);
    cycle(1'b1, 23'h3C3C3C);
    idle(FRAME + 10);
    check("post_reset_image", 32'(image), 32'h3C3C3C);
    $display("frame after reset: image=%06h", image);

    // Random strobes, including ones landing on latch exit and while pending.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) cycle(1'b1, 23'($urandom));
      else cycle(1'b0, 23'($urandom));
    end
    idle(2 * FRAME + 5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("random phase done: last image=%06h overruns=%0d", image, ov_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
